regfile_access_sched: RTL and testbench
=======================================

# regfile_access_sched

Sequencer that shares the single-port RV32I register file between the decode stage (two source-operand reads) and the writeback stage (one destination write). The register file has one port: a mode select (1 = read, 0 = write), an address, write data and combinational read data. This block serialises requests onto that port, arbitrates fairly when both stages request at once, and hardwires x0. It sits between the pipeline stages and the register file instance.

## Interface
- XLEN, 32, data width
- AW, 5, register address width

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  writeback request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  AW  destination register rd
- wr_data  in  XLEN  value to write
- rd_valid  in  1  operand-read request
- rd_ready  out  1  read request accepted this cycle
- rd_addr1  in  AW  rs1
- rd_addr2  in  AW  rs2
- resp_valid  out  1  operands available
- resp_ready  in  1  decode consumes operands
- resp_data1  out  XLEN  value of rs1
- resp_data2  out  XLEN  value of rs2
- rf_state  out  1  port mode to the register file: 1 = read, 0 = write
- rf_address  out  AW  port address
- rf_data_w  out  XLEN  port write data
- rf_data  in  XLEN  port read data, combinational from rf_address

## Operation
- FSM states: IDLE, WR, RD1, RD2, RESP.
- IDLE:
  - wr_ready and rd_ready may assert only in IDLE, and at most one of them per cycle.
  - Grant rule:
    - Only wr_valid: accept the write.
    - Only rd_valid: accept the read.
    - Both valid: grant the side not granted last (1-bit last_grant, reset = read, so the first contended grant goes to write).
  - Accepted write latches wr_addr and wr_data.
    - wr_addr != 0: go to WR.
    - wr_addr == 0: the write is dropped (no port write) and the FSM stays in IDLE. last_grant still updates.
  - Accepted read latches both addresses and goes to RD1.
- WR: rf_state=0, rf_address=latched rd, rf_data_w=latched data. Go to IDLE.
- RD1: rf_state=1, rf_address=latched rs1. Capture rf_data into resp_data1, or 0 if rs1 == 0. Go to RD2.
- RD2: same as RD1 for rs2 into resp_data2. Go to RESP.
- RESP: resp_valid=1. resp_data1/2 hold stable. Go to IDLE on resp_ready.
- In all states other than WR: rf_state=1, rf_data_w=0, rf_address=0 (except RD1/RD2).
- A read accepted after a write returns the written value, because port operations are strictly serial. There is no bypass path.
- A write to the same register as an in-flight read cannot occur, because nothing is accepted outside IDLE.

## Timing
- Reset values: FSM=IDLE, last_grant=read, wr_ready=0, rd_ready=0, resp_valid=0, resp_data1/2=0, rf_state=1, rf_address=0, rf_data_w=0.
- wr_ready and rd_ready are combinational from FSM state, last_grant and the valids.
- rf_* outputs are combinational from FSM state and the latched registers.
- Write accepted at cycle T: WR at T+1 (rf_state=0 for exactly one cycle). Next acceptance possible at T+2.
- Read accepted at T: RD1 at T+1, RD2 at T+2, resp_valid first high at T+3.
  - Response completes at the first cycle ≥ T+3 with resp_ready=1.
  - Next acceptance possible one cycle after that.
- x0 write: accepted at T, next acceptance possible at T+1.
- Read latency is fixed; x0 reads still spend their RD cycle.
- Reset at any cycle (mid-WR, RD1, RD2 or RESP):
  - Next cycle is IDLE with reset values.
  - The in-flight request is discarded.
  - No response is issued, and resp_valid never glitches high.

## Structure
- Shared package riscv_rf_pkg holds:
  - XLEN and AW defaults
  - RF_READ=1'b1 and RF_WRITE=1'b0 constants
  - the rf_sched_state_t enum (IDLE, WR, RD1, RD2, RESP)
- Flat implementation; no sub-module needed. The 2-requester round-robin is a single last_grant flop and is not split out.
- The register file itself is instantiated at the level above and wired to the rf_* ports.

## Test plan
- Write x1=0xF000000F, then read rs1=1, rs2=0 → exactly one rf_state=0 cycle with rf_address=1 and rf_data_w=0xF000000F. Response: resp_data1=0xF000000F, resp_data2=0x00000000, resp_valid 3 cycles after read accept.
- Write x0=0xFFFFFFFF, then read rs1=0, rs2=0 → wr_ready pulses, rf_state never goes 0, response is 0/0.
- After reset, wr_valid and rd_valid both held high; write x5=0x12345678, read rs1=5 rs2=5 → write granted first. Read then returns 0x12345678/0x12345678. On the next contention, read is granted first (alternation).
- Read completes with resp_ready held low for 3 cycles → resp_valid and resp_data stay stable. rd_ready and wr_ready stay 0 until the cycle after resp_ready rises.
- Assert rst during RD2 of a read → next cycle all outputs at reset values and no resp_valid. A following write x2=0xA5A5A5A5 followed by a read of x2 completes normally and returns 0xA5A5A5A5.
- Write-only stream of x3=1,2,3 back to back → accepts every 2 cycles; read of x3 returns 3.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// Shared definitions for the single-port RV32I register file and its access sequencer.
package riscv_rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic RF_READ  = 1'b1;
  localparam logic RF_WRITE = 1'b0;

  // Round-robin memory of which requester won the last grant.
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RESP = 3'd4
  } rf_sched_state_t;

endpackage

// File: rtl/regfile_access_sched_if.sv
// Pipeline-side request/response bundle: writeback write, decode operand read and operand response.
interface regfile_access_sched_if;
  import riscv_rf_pkg::*;

  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data1;
  logic [XLEN-1:0] resp_data2;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2, resp_ready,
    input  wr_ready, rd_ready, resp_valid, resp_data1, resp_data2
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2, resp_ready,
    output wr_ready, rd_ready, resp_valid, resp_data1, resp_data2
  );

endinterface

// File: rtl/regfile_access_sched.sv
// Serialises decode operand reads and writeback writes onto the single register-file port,
// alternating grants under contention and forcing x0 reads to zero.
module regfile_access_sched
  import riscv_rf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  regfile_access_sched_if.slave  bus,
  output logic                   rf_state,
  output logic [AW-1:0]          rf_address,
  output logic [XLEN-1:0]        rf_data_w,
  input  logic [XLEN-1:0]        rf_data
);

  rf_sched_state_t state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0] resp_data1_q, resp_data1_d;
  logic [XLEN-1:0] resp_data2_q, resp_data2_d;
  logic            wr_grant;
  logic            rd_grant;

  // Grants only from IDLE; a contended cycle goes to the side that lost last time.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (bus.wr_valid && bus.rd_valid) begin
        if (last_grant_q == GRANT_RD) begin
          wr_grant = 1'b1;
        end else begin
          rd_grant = 1'b1;
        end
      end else begin
        wr_grant = bus.wr_valid;
        rd_grant = bus.rd_valid;
      end
    end else begin
      wr_grant = 1'b0;
      rd_grant = 1'b0;
    end
  end

  assign bus.wr_ready   = wr_grant;
  assign bus.rd_ready   = rd_grant;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data1 = resp_data1_q;
  assign bus.resp_data2 = resp_data2_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    resp_data1_d = resp_data1_q;
    resp_data2_d = resp_data2_q;
    case (state_q)
      IDLE: begin
        if (wr_grant) begin
          wr_addr_d    = bus.wr_addr;
          wr_data_d    = bus.wr_data;
          last_grant_d = GRANT_WR;
          // A write to x0 is consumed here without ever touching the port.
          state_d      = (bus.wr_addr != {AW{1'b0}}) ? WR : IDLE;
        end else if (rd_grant) begin
          rs1_d        = bus.rd_addr1;
          rs2_d        = bus.rd_addr2;
          last_grant_d = GRANT_RD;
          state_d      = RD1;
        end else begin
          state_d = IDLE;
        end
      end
      WR:   state_d = IDLE;
      RD1: begin
        resp_data1_d = (rs1_q == {AW{1'b0}}) ? {XLEN{1'b0}} : rf_data;
        state_d      = RD2;
      end
      RD2: begin
        resp_data2_d = (rs2_q == {AW{1'b0}}) ? {XLEN{1'b0}} : rf_data;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      wr_addr_q    <= {AW{1'b0}};
      wr_data_q    <= {XLEN{1'b0}};
      rs1_q        <= {AW{1'b0}};
      rs2_q        <= {AW{1'b0}};
      resp_data1_q <= {XLEN{1'b0}};
      resp_data2_q <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      resp_data1_q <= resp_data1_d;
      resp_data2_q <= resp_data2_d;
    end
  end

  // Port drive: idle port is a read of x0 with zero write data.
  always_comb begin
    rf_state   = RF_READ;
    rf_address = {AW{1'b0}};
    rf_data_w  = {XLEN{1'b0}};
    case (state_q)
      WR: begin
        rf_state   = RF_WRITE;
        rf_address = wr_addr_q;
        rf_data_w  = wr_data_q;
      end
      RD1:     rf_address = rs1_q;
      RD2:     rf_address = rs2_q;
      default: rf_address = {AW{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_regfile_access_sched.sv
// Directed bench for regfile_access_sched: cycle vectors against a simple register-file model.
module tb_regfile_access_sched;
  import riscv_rf_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            rf_state;
  logic [AW-1:0]   rf_address;
  logic [XLEN-1:0] rf_data_w;
  logic [XLEN-1:0] rf_data;
  logic [XLEN-1:0] mem [0:31];
  int              wr_strobes = 0;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  regfile_access_sched_if bus();

  regfile_access_sched dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rf_state   (rf_state),
    .rf_address (rf_address),
    .rf_data_w  (rf_data_w),
    .rf_data    (rf_data)
  );

  // Register file model; x0 holds junk so the DUT must zero x0 reads itself.
  assign rf_data = mem[rf_address];
  always @(posedge clk) begin
    if (rf_state == 1'b0) begin
      mem[rf_address] <= rf_data_w;
      wr_strobes      <= wr_strobes + 1;
    end
  end

  typedef struct {
    string       nm;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        rr;
    logic        e_wrdy;
    logic        e_rrdy;
    logic        e_rsv;
    logic        e_rfs;
    logic [4:0]  e_rfa;
    logic [31:0] e_rfw;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic wv, logic [4:0] wa, logic [31:0] wd, logic rv,
                              logic [4:0] a1, logic [4:0] a2, logic rr, logic e_wrdy,
                              logic e_rrdy, logic e_rsv, logic e_rfs, logic [4:0] e_rfa,
                              logic [31:0] e_rfw, logic [31:0] e_d1, logic [31:0] e_d2);
    vec_t v;
    v.nm = nm; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.a1 = a1; v.a2 = a2; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_rsv = e_rsv; v.e_rfs = e_rfs;
    v.e_rfa = e_rfa; v.e_rfw = e_rfw; v.e_d1 = e_d1; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, compare on the falling edge, then advance.
  task automatic apply(vec_t v);
    bus.wr_valid   = v.wv;
    bus.wr_addr    = v.wa;
    bus.wr_data    = v.wd;
    bus.rd_valid   = v.rv;
    bus.rd_addr1   = v.a1;
    bus.rd_addr2   = v.a2;
    bus.resp_ready = v.rr;
    @(negedge clk);
    chk({v.nm, ".wr_ready"},   {31'd0, bus.wr_ready},   {31'd0, v.e_wrdy});
    chk({v.nm, ".rd_ready"},   {31'd0, bus.rd_ready},   {31'd0, v.e_rrdy});
    chk({v.nm, ".resp_valid"}, {31'd0, bus.resp_valid}, {31'd0, v.e_rsv});
    chk({v.nm, ".rf_state"},   {31'd0, rf_state},       {31'd0, v.e_rfs});
    chk({v.nm, ".rf_address"}, {27'd0, rf_address},     {27'd0, v.e_rfa});
    chk({v.nm, ".rf_data_w"},  rf_data_w,               v.e_rfw);
    chk({v.nm, ".resp_data1"}, bus.resp_data1,          v.e_d1);
    chk({v.nm, ".resp_data2"}, bus.resp_data2,          v.e_d2);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(string nm, logic wv, logic [4:0] wa, logic [31:0] wd, logic rv,
                     logic [4:0] a1, logic [4:0] a2, logic rr, logic e_wrdy, logic e_rrdy,
                     logic e_rsv, logic e_rfs, logic [4:0] e_rfa, logic [31:0] e_rfw,
                     logic [31:0] e_d1, logic [31:0] e_d2);
    apply(mk(nm, wv, wa, wd, rv, a1, a2, rr, e_wrdy, e_rrdy, e_rsv, e_rfs, e_rfa, e_rfw,
             e_d1, e_d2));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
    bus.rd_valid = 1'b0; bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0; bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0] = 32'hDEAD_BEEF;

    // Write x1 then read (x1, x0); then x0 write followed by read (x0, x0).
    vecs.push_back(mk("t1_wacc", 1'b1, 5'd1, 32'hF000_000F, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk("t1_wr",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'hF000_000F, 32'd0, 32'd0));
    vecs.push_back(mk("t1_racc", 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk("t1_rd1",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk("t1_rd2",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hF000_000F, 32'd0));
    vecs.push_back(mk("t1_resp", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'hF000_000F, 32'd0));
    vecs.push_back(mk("t2_wx0",  1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hF000_000F, 32'd0));
    vecs.push_back(mk("t2_racc", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'hF000_000F, 32'd0));
    vecs.push_back(mk("t2_rd1",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hF000_000F, 32'd0));
    vecs.push_back(mk("t2_rd2",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk("t2_resp", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk("t2_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0));

    do_reset();
    foreach (vecs[i]) apply(vecs[i]);
    chk("t1_strobes", wr_strobes, 32'd1);
    chk("t1_mem_x1", mem[1], 32'hF000_000F);
    chk("t2_mem_x0", mem[0], 32'hDEAD_BEEF);

    // Contention right after reset: write first, then read, then write again.
    do_reset();
    cyc("t3_both",  1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    cyc("t3_wr",    1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'd0, 32'd0);
    cyc("t3_both2", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    cyc("t3_rd1",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd0, 32'd0);
    cyc("t3_rd2",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234_5678, 32'd0);
    cyc("t3_resp",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t3_alt",   1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t3_altwr", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

    // Response held off for three cycles while both requesters are waiting.
    cyc("t4_racc",  1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t4_rd1",   1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t4_rd2",   1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234_5678, 32'h1234_5678);
    for (int i = 0; i < 3; i++)
      cyc("t4_stall", 1'b1, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t4_release", 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t4_after", 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t4_idle",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    chk("t4_strobes", wr_strobes, 32'd3);

    // Reset lands in RD2; the in-flight read must vanish.
    cyc("t5_racc",  1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    cyc("t5_rd1",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234_5678, 32'h1234_5678);
    rst = 1'b1;
    cyc("t5_inrst", 1'b1, 5'd7, 32'h0BAD_0BAD, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1234_5678, 32'h1234_5678);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("t5_post", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    chk("t5_mem_x7", mem[7], 32'd0);
    cyc("t5_wacc",  1'b1, 5'd2, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    cyc("t5_wr",    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'hA5A5_A5A5, 32'd0, 32'd0);
    cyc("t5_racc2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    cyc("t5_rd1b",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd0, 32'd0, 32'd0);
    cyc("t5_rd2b",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd0, 32'hA5A5_A5A5, 32'd0);
    cyc("t5_resp",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Back-to-back writes to x3 are accepted every other cycle.
    cyc("t6_w1",    1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_wr1",   1'b1, 5'd3, 32'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_w2",    1'b1, 5'd3, 32'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_wr2",   1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_w3",    1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_wr3",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_racc",  1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_rd1",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cyc("t6_rd2",   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'd3, 32'hA5A5_A5A5);
    cyc("t6_resp",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'd3, 32'd3);
    cyc("t6_idle",  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd3, 32'd3);
    chk("t6_strobes", wr_strobes, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
